// File: rtl/calc_core.sv
// Operand-entry and add/subtract controller for the remote-driven calculator.
// Collects nibble-wide digits into operands A and B and drives a registered display value.
module calc_core #(
  parameter int unsigned DIGITS = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  in1Sel,
  input  logic                  in2Sel,
  input  logic                  resultSel,
  input  logic                  sub,
  input  logic                  digit_valid,
  input  logic [3:0]            digit,
  output logic [4*DIGITS-1:0]   display,
  output logic                  carry,
  output logic                  ovf,
  output logic                  result_valid,
  output logic [1:0]            state
);

  localparam int unsigned WIDTH = 4 * DIGITS;
  localparam int unsigned CW    = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] CntMax = CW'(DIGITS);

  localparam logic [1:0] EnterA = 2'd0;
  localparam logic [1:0] EnterB = 2'd1;
  localparam logic [1:0] Result = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d, disp_q, disp_d;
  logic [CW-1:0]    cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic             carry_q, carry_d, ovf_q, ovf_d, rv_q, rv_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff, calc;
  logic             calc_carry, calc_ovf;

  always_comb begin
    sum  = {1'b0, opa_q} + {1'b0, opb_q};
    diff = opa_q - opb_q;
    calc = sub ? diff : sum[WIDTH-1:0];
    if (sub) begin
      calc_carry = (opa_q < opb_q);
      calc_ovf   = (opa_q[WIDTH-1] != opb_q[WIDTH-1]) && (calc[WIDTH-1] != opa_q[WIDTH-1]);
    end else begin
      calc_carry = sum[WIDTH];
      calc_ovf   = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) && (calc[WIDTH-1] != opa_q[WIDTH-1]);
    end
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    disp_d  = disp_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    rv_d    = rv_q;
    if (en) begin
      // Any asserted select consumes the cycle, so a coincident digit is dropped.
      if (in1Sel) begin
        state_d = EnterA;
        if (state_q == Result) begin
          opa_d   = '0;
          opb_d   = '0;
          cnt_a_d = '0;
          cnt_b_d = '0;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
        end
      end else if (in2Sel) begin
        state_d = EnterB;
      end else if (resultSel) begin
        state_d = Result;
        res_d   = calc;
        carry_d = calc_carry;
        ovf_d   = calc_ovf;
      end else begin
        case (state_q)
          EnterA: if (digit_valid && (cnt_a_q < CntMax)) begin
            opa_d   = WIDTH'({opa_q, digit});
            cnt_a_d = cnt_a_q + 1'b1;
          end
          EnterB: if (digit_valid && (cnt_b_q < CntMax)) begin
            opb_d   = WIDTH'({opb_q, digit});
            cnt_b_d = cnt_b_q + 1'b1;
          end
          Result:  ;
          default: state_d = EnterA;
        endcase
      end

      // Display trails the register it mirrors by one cycle.
      case (state_q)
        EnterA:  disp_d = opa_q;
        EnterB:  disp_d = opb_q;
        Result:  disp_d = res_q;
        default: disp_d = disp_q;
      endcase
      rv_d = (state_q == Result) && (state_d == Result);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EnterA;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      disp_q  <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      disp_q  <= disp_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      rv_q    <= rv_d;
    end
  end

  assign display      = disp_q;
  assign carry        = carry_q;
  assign ovf          = ovf_q;
  assign result_valid = rv_q;
  assign state        = state_q;

endmodule
